// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer.
//   XLEN        : result/value width
//   AREG_W      : architectural register index width
//   rob_entry_t : one buffer slot {valid, done, dest, value}
//   tag_inc     : modulo-DEPTH increment of a tag/pointer (DEPTH is a power of two)
package rob_pkg;

  localparam int XLEN   = 64;
  localparam int AREG_W = 6;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [AREG_W-1:0] dest;
    logic [XLEN-1:0]   value;
  } rob_entry_t;

  // DEPTH is a power of two, so masking is the modulo.
  function automatic int unsigned tag_inc(int unsigned tag, int unsigned n, int unsigned depth);
    return (tag + n) & (depth - 1);
  endfunction

endpackage

// File: rtl/rob_if.sv
// Bundle of every ROB-facing signal apart from clk/res.
//   flush            : synchronous discard of all entries
//   alloc_*          : two-wide dispatch allocation (slot 0 older than slot 1)
//   cmpl_*_int/_ls   : result write-back by tag from the int and ld/st units
//   *_rob2rf         : two in-order commit ports to the register file
//   empty/full       : occupancy status
// Modports: master = pipeline / register-file side, slave = the ROB itself.
interface rob_if #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
);
  import rob_pkg::*;

  logic              flush;

  logic              alloc_req_0;
  logic [AREG_W-1:0] alloc_dest_0;
  logic              alloc_req_1;
  logic [AREG_W-1:0] alloc_dest_1;
  logic              alloc_ready_0;
  logic              alloc_ready_1;
  logic [TAG_W-1:0]  alloc_tag_0;
  logic [TAG_W-1:0]  alloc_tag_1;

  logic              cmpl_en_int;
  logic [TAG_W-1:0]  cmpl_tag_int;
  logic [XLEN-1:0]   cmpl_value_int;
  logic              cmpl_en_ls;
  logic [TAG_W-1:0]  cmpl_tag_ls;
  logic [XLEN-1:0]   cmpl_value_ls;

  logic              write_en_0_rob2rf;
  logic [AREG_W-1:0] write_select_0_rob2rf;
  logic [XLEN-1:0]   value_0_rob2rf;
  logic              write_en_1_rob2rf;
  logic [AREG_W-1:0] write_select_1_rob2rf;
  logic [XLEN-1:0]   value_1_rob2rf;

  logic              empty;
  logic              full;

  modport master (
    output flush,
    output alloc_req_0, alloc_dest_0, alloc_req_1, alloc_dest_1,
    input  alloc_ready_0, alloc_ready_1, alloc_tag_0, alloc_tag_1,
    output cmpl_en_int, cmpl_tag_int, cmpl_value_int,
    output cmpl_en_ls, cmpl_tag_ls, cmpl_value_ls,
    input  write_en_0_rob2rf, write_select_0_rob2rf, value_0_rob2rf,
    input  write_en_1_rob2rf, write_select_1_rob2rf, value_1_rob2rf,
    input  empty, full
  );

  modport slave (
    input  flush,
    input  alloc_req_0, alloc_dest_0, alloc_req_1, alloc_dest_1,
    output alloc_ready_0, alloc_ready_1, alloc_tag_0, alloc_tag_1,
    input  cmpl_en_int, cmpl_tag_int, cmpl_value_int,
    input  cmpl_en_ls, cmpl_tag_ls, cmpl_value_ls,
    output write_en_0_rob2rf, write_select_0_rob2rf, value_0_rob2rf,
    output write_en_1_rob2rf, write_select_1_rob2rf, value_1_rob2rf,
    output empty, full
  );

endinterface

// File: rtl/rob_commit_sel.sv
// Commit readiness of the two oldest entries.
//   head_valid/head_done : state of entry[head]
//   next_valid/next_done : state of entry[head+1]
//   c0, c1               : commit head / head+1 this cycle
//   n_commit             : number of entries retired (0..2)
// head+1 may only retire together with head, which keeps retirement in order.
module rob_commit_sel (
  input  logic       head_valid,
  input  logic       head_done,
  input  logic       next_valid,
  input  logic       next_done,
  output logic       c0,
  output logic       c1,
  output logic [1:0] n_commit
);

  assign c0       = head_valid & head_done;
  assign c1       = c0 & next_valid & next_done;
  assign n_commit = {1'b0, c0} + {1'b0, c1};

endmodule

// File: rtl/rob.sv
// Reorder buffer: circular in-order queue between dispatch/execute and the
// register file.
//   clk : clock, all state on posedge
//   res : asynchronous active-high reset
//   bus : rob_if.slave -- allocation, completion, commit and status signals
// Up to two entries are allocated at the tail per cycle, results are written
// back by tag from two units (int has priority over ld/st on the same tag),
// and up to two done entries retire from the head onto registered RF ports.
module rob
  import rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic res,
  rob_if.slave bus
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] DEPTH_2 = (TAG_W+1)'(DEPTH - 2);

  rob_entry_t       entries [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic [TAG_W-1:0] head_nxt;
  logic [TAG_W-1:0] tail_nxt;
  logic             ready_0;
  logic             ready_1;
  logic [1:0]       n_alloc;
  logic             c0;
  logic             c1;
  logic [1:0]       n_commit;

  assign head_nxt = TAG_W'(tag_inc(32'(head), 1, DEPTH));
  assign tail_nxt = TAG_W'(tag_inc(32'(tail), 1, DEPTH));

  rob_commit_sel u_commit_sel (
    .head_valid (entries[head].valid),
    .head_done  (entries[head].done),
    .next_valid (entries[head_nxt].valid),
    .next_done  (entries[head_nxt].done),
    .c0         (c0),
    .c1         (c1),
    .n_commit   (n_commit)
  );

  // Status comes from the pre-edge count, so space freed by a commit shows up
  // one cycle later and a full buffer never allocates while it commits.
  always_comb begin
    ready_0 = count < DEPTH_C;
    ready_1 = count <= DEPTH_2;
    // NOTE: every always_comb output gets a value on every path (here via the
    // default first) so no latch is inferred.
    n_alloc = 2'd0;
    if (bus.alloc_req_0 && bus.alloc_req_1 && ready_1) begin
      n_alloc = 2'd2;
    end else if (bus.alloc_req_0 && ready_0) begin
      n_alloc = 2'd1;
    end
  end

  assign bus.alloc_ready_0 = ready_0;
  assign bus.alloc_ready_1 = ready_1;
  assign bus.alloc_tag_0   = tail;
  assign bus.alloc_tag_1   = tail_nxt;
  assign bus.empty         = count == '0;
  assign bus.full          = count == DEPTH_C;

  // NOTE: state uses non-blocking assignments, so every read below sees the
  // pre-edge value and later writes in this block override earlier ones.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      // NOTE: the entry array is small and its valid/done bits must clear
      // asynchronously, so the whole array sits on the reset.
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      head                      <= '0;
      tail                      <= '0;
      count                     <= '0;
      bus.write_en_0_rob2rf     <= 1'b0;
      bus.write_select_0_rob2rf <= '0;
      bus.value_0_rob2rf        <= '0;
      bus.write_en_1_rob2rf     <= 1'b0;
      bus.write_select_1_rob2rf <= '0;
      bus.value_1_rob2rf        <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
      head                  <= '0;
      tail                  <= '0;
      count                 <= '0;
      bus.write_en_0_rob2rf <= 1'b0;
      bus.write_en_1_rob2rf <= 1'b0;
    end else begin
      // Completion: ld/st first so an int result on the same tag overrides it.
      // Only entries valid before this edge accept a result.
      if (bus.cmpl_en_ls && entries[bus.cmpl_tag_ls].valid) begin
        entries[bus.cmpl_tag_ls].done  <= 1'b1;
        entries[bus.cmpl_tag_ls].value <= bus.cmpl_value_ls;
      end
      if (bus.cmpl_en_int && entries[bus.cmpl_tag_int].valid) begin
        entries[bus.cmpl_tag_int].done  <= 1'b1;
        entries[bus.cmpl_tag_int].value <= bus.cmpl_value_int;
      end

      // Commit: select/value hold when the port is idle.
      bus.write_en_0_rob2rf <= c0;
      if (c0) begin
        bus.write_select_0_rob2rf <= entries[head].dest;
        bus.value_0_rob2rf        <= entries[head].value;
        entries[head].valid       <= 1'b0;
        entries[head].done        <= 1'b0;
      end
      bus.write_en_1_rob2rf <= c1;
      if (c1) begin
        bus.write_select_1_rob2rf <= entries[head_nxt].dest;
        bus.value_1_rob2rf        <= entries[head_nxt].value;
        entries[head_nxt].valid   <= 1'b0;
        entries[head_nxt].done    <= 1'b0;
      end

      // Allocation targets free slots only, so it never collides with a
      // committing entry; it does override a same-edge completion to that tag.
      if (n_alloc != 2'd0) begin
        entries[tail].valid <= 1'b1;
        entries[tail].done  <= 1'b0;
        entries[tail].dest  <= bus.alloc_dest_0;
      end
      if (n_alloc == 2'd2) begin
        entries[tail_nxt].valid <= 1'b1;
        entries[tail_nxt].done  <= 1'b0;
        entries[tail_nxt].dest  <= bus.alloc_dest_1;
      end

      head  <= TAG_W'(tag_inc(32'(head), 32'(n_commit), DEPTH));
      tail  <= TAG_W'(tag_inc(32'(tail), 32'(n_alloc), DEPTH));
      count <= count + (TAG_W+1)'(n_alloc) - (TAG_W+1)'(n_commit);
    end
  end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios plus a randomized run
// compared against a program-order queue model of the buffer.
module tb_rob;
  import rob_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  rob_if #(.DEPTH(DEPTH)) bus ();

  rob #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight instructions in program order.
  typedef struct {
    int          tag;
    logic [5:0]  dest;
    bit          done;
    logic [63:0] value;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_tail;
  logic        exp_en0, exp_en1;
  logic [5:0]  exp_sel0, exp_sel1;
  logic [63:0] exp_val0, exp_val1;

  task automatic idle();
    bus.flush          = 1'b0;
    bus.alloc_req_0    = 1'b0;
    bus.alloc_dest_0   = '0;
    bus.alloc_req_1    = 1'b0;
    bus.alloc_dest_1   = '0;
    bus.cmpl_en_int    = 1'b0;
    bus.cmpl_tag_int   = '0;
    bus.cmpl_value_int = '0;
    bus.cmpl_en_ls     = 1'b0;
    bus.cmpl_tag_ls    = '0;
    bus.cmpl_value_ls  = '0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail   = 0;
    exp_en0  = 1'b0;
    exp_en1  = 1'b0;
    exp_sel0 = '0;
    exp_sel1 = '0;
    exp_val0 = '0;
    exp_val1 = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int pre  = mq.size();
    int ncom = 0;
    int nal  = 0;
    if (bus.flush) begin
      mq.delete();
      m_tail  = 0;
      exp_en0 = 1'b0;
      exp_en1 = 1'b0;
      return;
    end
    exp_en0 = 1'b0;
    exp_en1 = 1'b0;
    if (pre > 0 && mq[0].done) begin
      exp_en0 = 1'b1; exp_sel0 = mq[0].dest; exp_val0 = mq[0].value; ncom = 1;
      if (pre > 1 && mq[1].done) begin
        exp_en1 = 1'b1; exp_sel1 = mq[1].dest; exp_val1 = mq[1].value; ncom = 2;
      end
    end
    foreach (mq[i]) begin
      if (bus.cmpl_en_ls && mq[i].tag == int'(bus.cmpl_tag_ls)) begin
        mq[i].done = 1'b1; mq[i].value = bus.cmpl_value_ls;
      end
    end
    foreach (mq[i]) begin
      if (bus.cmpl_en_int && mq[i].tag == int'(bus.cmpl_tag_int)) begin
        mq[i].done = 1'b1; mq[i].value = bus.cmpl_value_int;
      end
    end
    repeat (ncom) void'(mq.pop_front());
    if (bus.alloc_req_0 && bus.alloc_req_1 && DEPTH - pre >= 2) nal = 2;
    else if (bus.alloc_req_0 && DEPTH - pre >= 1) nal = 1;
    for (int k = 0; k < nal; k++) begin
      mq.push_back('{tag: m_tail, dest: (k == 0) ? bus.alloc_dest_0 : bus.alloc_dest_1,
                     done: 1'b0, value: 64'd0});
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic apply_reset();
    idle();
    res = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic alloc(input logic r1, input logic [5:0] d0, input logic [5:0] d1);
    bus.alloc_req_0 = 1'b1; bus.alloc_dest_0 = d0;
    bus.alloc_req_1 = r1;   bus.alloc_dest_1 = d1;
  endtask

  task automatic cmpl_int(input logic [3:0] t, input logic [63:0] v);
    bus.cmpl_en_int = 1'b1; bus.cmpl_tag_int = t; bus.cmpl_value_int = v;
  endtask

  task automatic cmpl_ls(input logic [3:0] t, input logic [63:0] v);
    bus.cmpl_en_ls = 1'b1; bus.cmpl_tag_ls = t; bus.cmpl_value_ls = v;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
    checks++; if ({bus.alloc_ready_0, bus.alloc_ready_1} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b%b exp 11", bus.alloc_ready_0, bus.alloc_ready_1); end
    checks++; if (bus.alloc_tag_0 !== 4'd0 || bus.alloc_tag_1 !== 4'd1) begin errors++; $display("FAIL reset_tags got %0d/%0d exp 0/1", bus.alloc_tag_0, bus.alloc_tag_1); end
    checks++; if ({bus.write_en_0_rob2rf, bus.write_en_1_rob2rf} !== 2'b00) begin errors++; $display("FAIL reset_wen got %b%b exp 00", bus.write_en_0_rob2rf, bus.write_en_1_rob2rf); end
    checks++; if (bus.write_select_0_rob2rf !== 6'd0 || bus.value_0_rob2rf !== 64'd0 || bus.write_select_1_rob2rf !== 6'd0 || bus.value_1_rob2rf !== 64'd0) begin errors++; $display("FAIL reset_rfdata got %0d/%h %0d/%h exp zeros", bus.write_select_0_rob2rf, bus.value_0_rob2rf, bus.write_select_1_rob2rf, bus.value_1_rob2rf); end
  endtask

  task automatic test_pair_commit();
    apply_reset();
    alloc(1'b1, 6'd5, 6'd6);
    checks++; if (bus.alloc_tag_0 !== 4'd0 || bus.alloc_tag_1 !== 4'd1) begin errors++; $display("FAIL pair_tags got %0d/%0d exp 0/1", bus.alloc_tag_0, bus.alloc_tag_1); end
    tick();
    cmpl_int(4'd1, 64'hBB);
    cmpl_ls(4'd0, 64'hAA);
    tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b0) begin errors++; $display("FAIL pair_early_commit got %b exp 0", bus.write_en_0_rob2rf); end
    tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b1 || bus.write_select_0_rob2rf !== 6'd5 || bus.value_0_rob2rf !== 64'hAA) begin errors++; $display("FAIL pair_port0 got %b/%0d/%h exp 1/5/aa", bus.write_en_0_rob2rf, bus.write_select_0_rob2rf, bus.value_0_rob2rf); end
    checks++; if (bus.write_en_1_rob2rf !== 1'b1 || bus.write_select_1_rob2rf !== 6'd6 || bus.value_1_rob2rf !== 64'hBB) begin errors++; $display("FAIL pair_port1 got %b/%0d/%h exp 1/6/bb", bus.write_en_1_rob2rf, bus.write_select_1_rob2rf, bus.value_1_rob2rf); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL pair_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_out_of_order();
    apply_reset();
    alloc(1'b1, 6'd1, 6'd2); tick();
    alloc(1'b0, 6'd3, 6'd0);
    checks++; if (bus.alloc_tag_0 !== 4'd2) begin errors++; $display("FAIL ooo_tag got %0d exp 2", bus.alloc_tag_0); end
    tick();
    cmpl_int(4'd2, 64'h102); tick();
    cmpl_ls(4'd1, 64'h101); tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b0) begin errors++; $display("FAIL ooo_hold1 got %b exp 0", bus.write_en_0_rob2rf); end
    cmpl_int(4'd0, 64'h100); tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b0) begin errors++; $display("FAIL ooo_hold2 got %b exp 0", bus.write_en_0_rob2rf); end
    tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b1 || bus.write_select_0_rob2rf !== 6'd1 || bus.value_0_rob2rf !== 64'h100 || bus.write_en_1_rob2rf !== 1'b1 || bus.write_select_1_rob2rf !== 6'd2 || bus.value_1_rob2rf !== 64'h101) begin errors++; $display("FAIL ooo_first_pair got %b/%0d/%h %b/%0d/%h exp 1/1/100 1/2/101", bus.write_en_0_rob2rf, bus.write_select_0_rob2rf, bus.value_0_rob2rf, bus.write_en_1_rob2rf, bus.write_select_1_rob2rf, bus.value_1_rob2rf); end
    tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b1 || bus.write_select_0_rob2rf !== 6'd3 || bus.value_0_rob2rf !== 64'h102 || bus.write_en_1_rob2rf !== 1'b0) begin errors++; $display("FAIL ooo_third got %b/%0d/%h en1 %b exp 1/3/102 en1 0", bus.write_en_0_rob2rf, bus.write_select_0_rob2rf, bus.value_0_rob2rf, bus.write_en_1_rob2rf); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ooo_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      alloc(1'b0, 6'(i), 6'd0); tick();
    end
    checks++; if (bus.alloc_tag_0 !== 4'd15 || bus.alloc_tag_1 !== 4'd0) begin errors++; $display("FAIL wrap_tags got %0d/%0d exp 15/0", bus.alloc_tag_0, bus.alloc_tag_1); end
    checks++; if (bus.alloc_ready_0 !== 1'b1 || bus.alloc_ready_1 !== 1'b0) begin errors++; $display("FAIL one_free_ready got %b%b exp 10", bus.alloc_ready_0, bus.alloc_ready_1); end
    alloc(1'b1, 6'd15, 6'd16); tick();
    checks++; if (bus.full !== 1'b1 || bus.alloc_ready_0 !== 1'b0 || bus.alloc_tag_0 !== 4'd0) begin errors++; $display("FAIL full_state got full %b rdy %b tag %0d exp 1/0/0", bus.full, bus.alloc_ready_0, bus.alloc_tag_0); end
    alloc(1'b0, 6'd50, 6'd0); tick();
    checks++; if (bus.full !== 1'b1 || bus.alloc_tag_0 !== 4'd0) begin errors++; $display("FAIL full_req_ignored got full %b tag %0d exp 1/0", bus.full, bus.alloc_tag_0); end
    cmpl_int(4'd0, 64'h1234); tick();
    checks++; if (bus.alloc_ready_0 !== 1'b0) begin errors++; $display("FAIL full_commit_cycle_ready got %b exp 0", bus.alloc_ready_0); end
    alloc(1'b0, 6'd51, 6'd0); tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b1 || bus.write_select_0_rob2rf !== 6'd0 || bus.value_0_rob2rf !== 64'h1234 || bus.write_en_1_rob2rf !== 1'b0) begin errors++; $display("FAIL full_commit got %b/%0d/%h en1 %b exp 1/0/1234 en1 0", bus.write_en_0_rob2rf, bus.write_select_0_rob2rf, bus.value_0_rob2rf, bus.write_en_1_rob2rf); end
    checks++; if (bus.full !== 1'b0 || bus.alloc_ready_0 !== 1'b1 || bus.alloc_tag_0 !== 4'd0) begin errors++; $display("FAIL after_commit got full %b rdy %b tag %0d exp 0/1/0", bus.full, bus.alloc_ready_0, bus.alloc_tag_0); end
    alloc(1'b0, 6'd52, 6'd0); tick();
    checks++; if (bus.full !== 1'b1 || bus.alloc_tag_0 !== 4'd1) begin errors++; $display("FAIL refill got full %b tag %0d exp 1/1", bus.full, bus.alloc_tag_0); end
  endtask

  task automatic test_same_tag();
    apply_reset();
    alloc(1'b1, 6'd10, 6'd11); tick();
    alloc(1'b1, 6'd12, 6'd13); tick();
    cmpl_int(4'd0, 64'hA0); cmpl_ls(4'd1, 64'hA1); tick();
    cmpl_int(4'd2, 64'hA2); tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b1 || bus.value_0_rob2rf !== 64'hA0 || bus.write_en_1_rob2rf !== 1'b1 || bus.write_select_1_rob2rf !== 6'd11) begin errors++; $display("FAIL same_pre_pair got %b/%h %b/%0d exp 1/a0 1/11", bus.write_en_0_rob2rf, bus.value_0_rob2rf, bus.write_en_1_rob2rf, bus.write_select_1_rob2rf); end
    cmpl_int(4'd3, 64'h11); cmpl_ls(4'd3, 64'h22); tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b1 || bus.write_select_0_rob2rf !== 6'd12 || bus.write_en_1_rob2rf !== 1'b0) begin errors++; $display("FAIL same_tag2 got %b/%0d en1 %b exp 1/12 en1 0", bus.write_en_0_rob2rf, bus.write_select_0_rob2rf, bus.write_en_1_rob2rf); end
    tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b1 || bus.write_select_0_rob2rf !== 6'd13 || bus.value_0_rob2rf !== 64'h11) begin errors++; $display("FAIL int_wins got %b/%0d/%h exp 1/13/11", bus.write_en_0_rob2rf, bus.write_select_0_rob2rf, bus.value_0_rob2rf); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL same_empty got %b exp 1", bus.empty); end
    cmpl_int(4'd4, 64'h99); tick();
    alloc(1'b0, 6'd20, 6'd0); cmpl_int(4'd4, 64'h77);
    checks++; if (bus.alloc_tag_0 !== 4'd4) begin errors++; $display("FAIL stale_tag got %0d exp 4", bus.alloc_tag_0); end
    tick(); tick(); tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b0 || bus.empty !== 1'b0) begin errors++; $display("FAIL stale_cmpl_ignored got en %b empty %b exp 0/0", bus.write_en_0_rob2rf, bus.empty); end
    cmpl_ls(4'd4, 64'h55); tick(); tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b1 || bus.write_select_0_rob2rf !== 6'd20 || bus.value_0_rob2rf !== 64'h55) begin errors++; $display("FAIL late_cmpl got %b/%0d/%h exp 1/20/55", bus.write_en_0_rob2rf, bus.write_select_0_rob2rf, bus.value_0_rob2rf); end
  endtask

  task automatic test_flush();
    apply_reset();
    alloc(1'b1, 6'd1, 6'd2); tick();
    alloc(1'b1, 6'd3, 6'd4); tick();
    alloc(1'b0, 6'd5, 6'd0); tick();
    cmpl_int(4'd0, 64'hF0); cmpl_ls(4'd1, 64'hF1); tick();
    bus.flush = 1'b1; alloc(1'b1, 6'd9, 6'd9); cmpl_int(4'd2, 64'hF2); tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b0 || bus.write_en_1_rob2rf !== 1'b0) begin errors++; $display("FAIL flush_wen got %b%b exp 00", bus.write_en_0_rob2rf, bus.write_en_1_rob2rf); end
    checks++; if (bus.empty !== 1'b1 || bus.alloc_tag_0 !== 4'd0 || bus.alloc_tag_1 !== 4'd1) begin errors++; $display("FAIL flush_state got empty %b tags %0d/%0d exp 1 0/1", bus.empty, bus.alloc_tag_0, bus.alloc_tag_1); end
    alloc(1'b1, 6'd7, 6'd8); tick(); tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b0 || bus.alloc_tag_0 !== 4'd2) begin errors++; $display("FAIL post_flush got en %b tag %0d exp 0/2", bus.write_en_0_rob2rf, bus.alloc_tag_0); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    alloc(1'b1, 6'd30, 6'd31); tick();
    alloc(1'b1, 6'd32, 6'd33); tick();
    cmpl_int(4'd0, 64'hC0); cmpl_ls(4'd1, 64'hC1); tick();
    cmpl_int(4'd2, 64'hC2); cmpl_ls(4'd3, 64'hC3); tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b1 || bus.value_1_rob2rf !== 64'hC1) begin errors++; $display("FAIL burst_start got %b/%h exp 1/c1", bus.write_en_0_rob2rf, bus.value_1_rob2rf); end
    #2 res = 1'b1;
    #1;
    checks++; if ({bus.write_en_0_rob2rf, bus.write_en_1_rob2rf} !== 2'b00 || bus.write_select_0_rob2rf !== 6'd0 || bus.value_0_rob2rf !== 64'd0 || bus.write_select_1_rob2rf !== 6'd0 || bus.value_1_rob2rf !== 64'd0) begin errors++; $display("FAIL async_reset_rf got %b%b %0d/%h %0d/%h exp zeros", bus.write_en_0_rob2rf, bus.write_en_1_rob2rf, bus.write_select_0_rob2rf, bus.value_0_rob2rf, bus.write_select_1_rob2rf, bus.value_1_rob2rf); end
    checks++; if (bus.empty !== 1'b1 || bus.alloc_tag_0 !== 4'd0 || bus.alloc_tag_1 !== 4'd1) begin errors++; $display("FAIL async_reset_state got empty %b tags %0d/%0d exp 1 0/1", bus.empty, bus.alloc_tag_0, bus.alloc_tag_1); end
    model_reset();
    @(negedge clk);
    res = 1'b0;
    tick(); tick();
    checks++; if (bus.write_en_0_rob2rf !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL reset_cleared_done got en %b empty %b exp 0/1", bus.write_en_0_rob2rf, bus.empty); end
  endtask

  task automatic pick_cmpl(input int pct, output logic en, output logic [3:0] tag, output logic [63:0] val);
    int idx;
    en  = 1'b0;
    tag = 4'($urandom);
    val = {$urandom, $urandom};
    if (mq.size() > 0 && $urandom_range(0, 99) < pct) begin
      idx = $urandom_range(0, mq.size() - 1);
      if (!mq[idx].done) begin
        en  = 1'b1;
        tag = 4'(mq[idx].tag);
      end
    end else if ($urandom_range(0, 7) == 0) begin
      en = 1'b1;
    end
  endtask

  task automatic test_random();
    int pct_tab[3] = '{15, 90, 55};
    logic e; logic [3:0] t; logic [63:0] v;
    int sz;
    apply_reset();
    for (int ph = 0; ph < 3; ph++) begin
      for (int cyc = 0; cyc < 150; cyc++) begin
        bus.alloc_req_0  = 1'($urandom_range(0, 3) != 0);
        bus.alloc_req_1  = 1'($urandom_range(0, 1));
        bus.alloc_dest_0 = 6'($urandom);
        bus.alloc_dest_1 = 6'($urandom);
        pick_cmpl(pct_tab[ph], e, t, v);
        bus.cmpl_en_int = e; bus.cmpl_tag_int = t; bus.cmpl_value_int = v;
        pick_cmpl(pct_tab[ph], e, t, v);
        bus.cmpl_en_ls = e; bus.cmpl_tag_ls = t; bus.cmpl_value_ls = v;
        bus.flush = 1'($urandom_range(0, 63) == 0);
        sz = mq.size();
        checks++;
        if (bus.empty !== 1'(sz == 0) || bus.full !== 1'(sz == DEPTH) ||
            bus.alloc_ready_0 !== 1'(sz < DEPTH) || bus.alloc_ready_1 !== 1'(sz <= DEPTH - 2) ||
            bus.alloc_tag_0 !== 4'(m_tail) || bus.alloc_tag_1 !== 4'((m_tail + 1) % DEPTH)) begin
          errors++;
          $display("FAIL rand_status ph %0d cyc %0d got e%b f%b r%b%b tags %0d/%0d exp count %0d tail %0d",
                   ph, cyc, bus.empty, bus.full, bus.alloc_ready_0, bus.alloc_ready_1,
                   bus.alloc_tag_0, bus.alloc_tag_1, sz, m_tail);
        end
        tick();
        checks++;
        if (bus.write_en_0_rob2rf !== exp_en0 || bus.write_select_0_rob2rf !== exp_sel0 || bus.value_0_rob2rf !== exp_val0 ||
            bus.write_en_1_rob2rf !== exp_en1 || bus.write_select_1_rob2rf !== exp_sel1 || bus.value_1_rob2rf !== exp_val1) begin
          errors++;
          $display("FAIL rand_commit ph %0d cyc %0d got %b/%0d/%h %b/%0d/%h exp %b/%0d/%h %b/%0d/%h",
                   ph, cyc, bus.write_en_0_rob2rf, bus.write_select_0_rob2rf, bus.value_0_rob2rf,
                   bus.write_en_1_rob2rf, bus.write_select_1_rob2rf, bus.value_1_rob2rf,
                   exp_en0, exp_sel0, exp_val0, exp_en1, exp_sel1, exp_val1);
        end
      end
    end
  endtask

  initial begin
    res = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_pair_commit();
    test_out_of_order();
    test_full_wrap();
    test_same_tag();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
